// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered valid/ready grant port.
// A cold mask over bits above the last accepted index rotates priority.
module rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         req_vec,
  input  logic                     grant_ready,
  output logic                     grant_valid,
  output logic [WIDTH-1:0]         grant_one_hot,
  output logic [$clog2(WIDTH)-1:0] grant_index
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] oh_q, oh_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] cold;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] win;

  function automatic logic [WIDTH-1:0] lsb_oh(
    input logic [WIDTH-1:0] v
  );
    return v & (~v + WIDTH'(1));
  endfunction

  function automatic logic [IW-1:0] oh2idx(
    input logic [WIDTH-1:0] oh
  );
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      if (oh[i]) r = r | IW'(i);
    return r;
  endfunction

  // Masked winner first; fall back to the unmasked lowest requester.
  function automatic logic [WIDTH-1:0] pick(
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH-1:0] cm;
    cm = c & m;
    return (cm != '0) ? lsb_oh(cm) : lsb_oh(c);
  endfunction

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    oh_d    = oh_q;
    idx_d   = idx_q;
    cand    = '0;
    win     = '0;
    cold    = '0;
    for (int i = 0; i < WIDTH; i++)
      cold[i] = (i > int'(idx_q));
    unique case (state_q)
      IDLE: begin
        if (req_vec != '0) begin
          win     = pick(req_vec, mask_q);
          state_d = GRANTED;
          valid_d = 1'b1;
          oh_d    = win;
          idx_d   = oh2idx(win);
        end
      end
      GRANTED: begin
        if (grant_ready) begin
          mask_d = cold;
          cand   = req_vec & ~oh_q;
          if (cand != '0) begin
            win   = pick(cand, cold);
            oh_d  = win;
            idx_d = oh2idx(win);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            oh_d    = '0;
            idx_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      mask_q  <= '1;
      valid_q <= 1'b0;
      oh_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      oh_q    <= oh_d;
      idx_q   <= idx_d;
    end
  end

  assign grant_valid   = valid_q;
  assign grant_one_hot = oh_q;
  assign grant_index   = idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus a randomized run
// against a search-based round-robin model.
module tb_rr_arbiter;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic [W-1:0] req_vec;
  logic         grant_ready;
  logic         grant_valid;
  logic [W-1:0] grant_one_hot;
  logic [2:0]   grant_index;

  int checks = 0;
  int passes = 0;

  // model: valid flag, granted index, last accepted index (-1 = none)
  bit m_valid;
  int m_idx;
  int m_last;

  rr_arbiter #(.WIDTH(W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_vec      (req_vec),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_one_hot(grant_one_hot),
    .grant_index  (grant_index)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int pick(input logic [W-1:0] c, input int last);
    for (int i = last + 1; i < W; i++)
      if (c[i]) return i;
    for (int i = 0; i < W; i++)
      if (c[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_idx   = 0;
    m_last  = -1;
  endtask

  task automatic model_clk(input logic [W-1:0] r, input logic rdy);
    logic [W-1:0] c;
    if (!m_valid) begin
      if (r != '0) begin
        m_idx   = pick(r, m_last);
        m_valid = 1;
      end
    end else if (rdy) begin
      m_last = m_idx;
      c = r;
      c[m_idx] = 1'b0;
      if (c != '0) m_idx = pick(c, m_last);
      else begin
        m_valid = 0;
        m_idx   = 0;
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req_vec = '0;
    grant_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    req_vec = 8'hFF;
    grant_ready = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      checks++;
      if (grant_valid !== 1'b0 || grant_one_hot !== 8'h00 || grant_index !== 3'd0)
        $display("FAIL reset_hold: v=%b oh=%b idx=%0d want 0/00000000/0",
                 grant_valid, grant_one_hot, grant_index);
      else passes++;
    end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (grant_valid !== 1'b1 || grant_one_hot !== 8'h01 || grant_index !== 3'd0)
      $display("FAIL reset_release: v=%b oh=%b idx=%0d want 1/00000001/0",
               grant_valid, grant_one_hot, grant_index);
    else passes++;
  endtask

  task automatic test_alternation();
    logic [2:0] exp;
    do_reset();
    req_vec = 8'h05;
    grant_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      exp = (k % 2 == 0) ? 3'd0 : 3'd2;
      checks++;
      if (grant_valid !== 1'b1 || grant_index !== exp)
        $display("FAIL alternation[%0d]: v=%b idx=%0d want 1/%0d",
                 k, grant_valid, grant_index, exp);
      else passes++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_vec = 8'h80;
    grant_ready = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (grant_valid !== 1'b1 || grant_index !== 3'd7)
      $display("FAIL stall_grant: v=%b idx=%0d want 1/7", grant_valid, grant_index);
    else passes++;
    @(negedge CLK);
    req_vec = 8'h01;
    repeat (3) begin
      @(posedge CLK); #1;
      checks++;
      if (grant_valid !== 1'b1 || grant_index !== 3'd7 || grant_one_hot !== 8'h80)
        $display("FAIL stall_hold: v=%b oh=%b idx=%0d want 1/10000000/7",
                 grant_valid, grant_one_hot, grant_index);
      else passes++;
    end
    @(negedge CLK);
    grant_ready = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (grant_valid !== 1'b1 || grant_index !== 3'd0 || grant_one_hot !== 8'h01)
      $display("FAIL stall_next: v=%b oh=%b idx=%0d want 1/00000001/0",
               grant_valid, grant_one_hot, grant_index);
    else passes++;
  endtask

  task automatic test_wrap();
    logic ev;
    logic [2:0] ei;
    logic [W-1:0] eo;
    do_reset();
    req_vec = 8'h80;
    grant_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      ev = (k % 2 == 0);
      ei = ev ? 3'd7 : 3'd0;
      eo = ev ? 8'h80 : 8'h00;
      checks++;
      if (grant_valid !== ev || grant_index !== ei || grant_one_hot !== eo)
        $display("FAIL wrap[%0d]: v=%b oh=%b idx=%0d want %b/%b/%0d",
                 k, grant_valid, grant_one_hot, grant_index, ev, eo, ei);
      else passes++;
    end
  endtask

  task automatic test_fairness();
    logic [2:0] ei;
    do_reset();
    req_vec = 8'hFF;
    grant_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge CLK); #1;
      ei = 3'(k % 8);
      checks++;
      if (grant_valid !== 1'b1 || grant_index !== ei)
        $display("FAIL fairness[%0d]: v=%b idx=%0d want 1/%0d",
                 k, grant_valid, grant_index, ei);
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_vec = 8'h08;
    grant_ready = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (grant_valid !== 1'b1 || grant_index !== 3'd3)
      $display("FAIL midrst_grant: v=%b idx=%0d want 1/3", grant_valid, grant_index);
    else passes++;
    #1 RST = 1'b1;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || grant_one_hot !== 8'h00 || grant_index !== 3'd0)
      $display("FAIL midrst_async: v=%b oh=%b idx=%0d want 0/00000000/0",
               grant_valid, grant_one_hot, grant_index);
    else passes++;
    @(negedge CLK);
    RST = 1'b0;
    req_vec = 8'h09;
    @(posedge CLK); #1;
    checks++;
    if (grant_valid !== 1'b1 || grant_index !== 3'd0 || grant_one_hot !== 8'h01)
      $display("FAIL midrst_after: v=%b oh=%b idx=%0d want 1/00000001/0",
               grant_valid, grant_one_hot, grant_index);
    else passes++;
  endtask

  task automatic test_random();
    logic [W-1:0] eo;
    logic [2:0]   ei;
    int           pos;
    do_reset();
    model_reset();
    for (int k = 0; k < 400; k++) begin
      req_vec = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      grant_ready = ($urandom_range(0, 3) != 0);
      model_clk(req_vec, grant_ready);
      @(posedge CLK); #1;
      eo = m_valid ? (8'h01 << m_idx) : 8'h00;
      ei = 3'(m_idx);
      checks++;
      if (grant_valid !== m_valid || grant_one_hot !== eo || grant_index !== ei)
        $display("FAIL random[%0d]: v=%b oh=%b idx=%0d want %b/%b/%0d",
                 k, grant_valid, grant_one_hot, grant_index, m_valid, eo, ei);
      else passes++;
      pos = 0;
      for (int i = 0; i < W; i++)
        if (grant_one_hot[i]) pos = i;
      checks++;
      if ($countones(grant_one_hot) > 1 || grant_index !== 3'(pos))
        $display("FAIL consistency[%0d]: oh=%b idx=%0d", k, grant_one_hot, grant_index);
      else passes++;
      @(negedge CLK);
    end
  endtask

  initial begin
    RST = 1'b1;
    req_vec = '0;
    grant_ready = 1'b0;
    test_reset();
    test_alternation();
    test_stall();
    test_wrap();
    test_fairness();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
